// File: rtl/conv2d_opt_mem_reader_pkg.sv
// Shared definitions for the conv2D optimized accelerator read path.
// State encodings, memory word size and small arithmetic helpers.
package conv2D_opt_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      REQ_WT  = 2'b01,
      REQ_IFM = 2'b10,
      DRAIN   = 2'b11
   } rd_state_t;

   localparam int unsigned WORD_BYTES = 4;

   // Square of a dimension, deliberately truncated to 32 bits.
   function automatic logic [31:0] sq32(input logic [31:0] d);
      return d * d;
   endfunction

endpackage

// File: rtl/conv2d_opt_mem_reader_fifo.sv
// Synchronous FIFO with occupancy count; asynchronous reset flushes it.
// The output word reads as zero whenever the FIFO is empty.
module fifo #(
   parameter int WIDTH    = 32,
   parameter int LOGDEPTH = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enq_valid,
   input  logic [WIDTH-1:0]    enq_data,
   output logic                deq_valid,
   output logic [WIDTH-1:0]    deq_data,
   input  logic                deq_ready,
   output logic [LOGDEPTH:0]   count
);
   localparam int unsigned DEPTH = 1 << LOGDEPTH;
   localparam logic [LOGDEPTH:0] FULL_COUNT = (LOGDEPTH+1)'(DEPTH);

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [LOGDEPTH-1:0] wptr;
   logic [LOGDEPTH-1:0] rptr;
   logic [LOGDEPTH:0]   cnt;
   logic                do_enq;
   logic                do_deq;

   assign deq_valid = (cnt != '0);
   assign deq_data  = deq_valid ? mem[rptr] : '0;
   assign do_enq    = enq_valid && (cnt != FULL_COUNT);
   assign do_deq    = deq_valid && deq_ready;
   assign count     = cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_enq) wptr <= wptr + 1'b1;
         if (do_deq) rptr <= rptr + 1'b1;
         cnt <= cnt + (LOGDEPTH+1)'(do_enq) - (LOGDEPTH+1)'(do_deq);
      end
   end

   always_ff @(posedge clk) begin
      if (do_enq) mem[wptr] <= enq_data;
   end

endmodule

// File: rtl/conv2d_opt_mem_reader.sv
// Read engine: fetches the weight matrix then the input feature map from memory
// and streams them in address order, throttling requests by buffer credit.
module conv2d_opt_mem_reader
   import conv2D_opt_pkg::*;
#(
   parameter int AWIDTH   = 32,
   parameter int DWIDTH   = 32,
   parameter int WT_DIM   = 3,
   parameter int LOGDEPTH = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              idle,
   input  logic [31:0]       fm_dim,
   input  logic [AWIDTH-1:0] wt_base_addr,
   input  logic [AWIDTH-1:0] ifm_base_addr,
   output logic [AWIDTH-1:0] req_addr,
   output logic              req_valid,
   input  logic              req_ready,
   input  logic [DWIDTH-1:0] resp_data,
   input  logic              resp_valid,
   output logic [DWIDTH-1:0] rdata,
   output logic              rdata_valid,
   input  logic              rdata_ready
);
   localparam int unsigned         DEPTH        = 1 << LOGDEPTH;
   localparam logic [31:0]         WT_LAST      = 32'(WT_DIM * WT_DIM - 1);
   localparam logic [AWIDTH-1:0]   ADDR_STEP    = AWIDTH'(WORD_BYTES);
   localparam logic [LOGDEPTH+1:0] CREDIT_LIMIT = (LOGDEPTH+2)'(DEPTH);

   rd_state_t           state;
   rd_state_t           state_nxt;
   logic [31:0]         fm_dim_q;
   logic [31:0]         fm_last;
   logic [31:0]         idx;
   logic [31:0]         idx_nxt;
   logic [AWIDTH-1:0]   ifm_base_q;
   logic [AWIDTH-1:0]   addr_q;
   logic [AWIDTH-1:0]   addr_nxt;
   logic [LOGDEPTH:0]   outstanding;
   logic [LOGDEPTH:0]   outstanding_nxt;
   logic [LOGDEPTH:0]   buf_count;
   logic [LOGDEPTH:0]   buf_count_nxt;
   logic [LOGDEPTH+1:0] credit_used;
   logic                latch_en;
   logic                in_req;
   logic                fire;
   logic                enq;
   logic                deq;

   assign fm_last     = sq32(fm_dim_q) - 32'd1;
   assign in_req      = (state == REQ_WT) || (state == REQ_IFM);
   assign credit_used = {1'b0, outstanding} + {1'b0, buf_count};
   assign req_valid   = in_req && (credit_used < CREDIT_LIMIT);
   assign fire        = req_valid && req_ready;
   // Responses with nothing outstanding are leftovers from before a reset.
   assign enq         = resp_valid && (outstanding != '0);
   assign deq         = rdata_valid && rdata_ready;
   assign idle        = (state == IDLE);
   assign req_addr    = addr_q;

   assign outstanding_nxt = outstanding + (LOGDEPTH+1)'(fire) - (LOGDEPTH+1)'(enq);
   assign buf_count_nxt   = buf_count + (LOGDEPTH+1)'(enq) - (LOGDEPTH+1)'(deq);

   fifo #(
      .WIDTH    (DWIDTH),
      .LOGDEPTH (LOGDEPTH)
   ) u_resp_buf (
      .clk       (clk),
      .rst       (rst),
      .enq_valid (enq),
      .enq_data  (resp_data),
      .deq_valid (rdata_valid),
      .deq_data  (rdata),
      .deq_ready (rdata_ready),
      .count     (buf_count)
   );

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      addr_nxt  = addr_q;
      latch_en  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = REQ_WT;
               idx_nxt   = '0;
               addr_nxt  = wt_base_addr;
               latch_en  = 1'b1;
            end
         end
         REQ_WT: begin
            if (fire) begin
               if (idx == WT_LAST) begin
                  state_nxt = (fm_dim_q == '0) ? DRAIN : REQ_IFM;
                  idx_nxt   = '0;
                  addr_nxt  = ifm_base_q;
               end else begin
                  idx_nxt  = idx + 32'd1;
                  addr_nxt = addr_q + ADDR_STEP;
               end
            end
         end
         REQ_IFM: begin
            if (fire) begin
               if (idx == fm_last) begin
                  state_nxt = DRAIN;
               end else begin
                  idx_nxt  = idx + 32'd1;
                  addr_nxt = addr_q + ADDR_STEP;
               end
            end
         end
         DRAIN: begin
            // Look at next-cycle occupancy so idle follows the final pop directly.
            if ((outstanding_nxt == '0) && (buf_count_nxt == '0)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         addr_q      <= '0;
         outstanding <= '0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         addr_q      <= addr_nxt;
         outstanding <= outstanding_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fm_dim_q   <= '0;
         ifm_base_q <= '0;
      end else if (latch_en) begin
         fm_dim_q   <= fm_dim;
         ifm_base_q <= ifm_base_addr;
      end
   end

endmodule

// File: tb/tb_conv2d_opt_mem_reader.sv
// Bench for conv2d_opt_mem_reader: a fixed-latency memory model, an in-order
// stream model and per-cycle protocol checks on the falling clock edge.
module tb_conv2d_opt_mem_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        idle;
   logic [31:0] fm_dim = '0;
   logic [31:0] wt_base_addr = '0;
   logic [31:0] ifm_base_addr = '0;
   logic [31:0] req_addr;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [31:0] resp_data = '0;
   logic        resp_valid = 1'b0;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        rdata_ready = 1'b0;

   conv2d_opt_mem_reader #(
      .AWIDTH   (32),
      .DWIDTH   (32),
      .WT_DIM   (3),
      .LOGDEPTH (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .idle          (idle),
      .fm_dim        (fm_dim),
      .wt_base_addr  (wt_base_addr),
      .ifm_base_addr (ifm_base_addr),
      .req_addr      (req_addr),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .resp_data     (resp_data),
      .resp_valid    (resp_valid),
      .rdata         (rdata),
      .rdata_valid   (rdata_valid),
      .rdata_ready   (rdata_ready)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          due;
      int          ep;
   } mresp_t;

   mresp_t      mem_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] log_addr[$];
   logic [31:0] got_data[$];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int lat = 2;
   int hold_until = 0;
   bit toggle_rdy = 1'b0;
   int epoch = 0;
   int fired = 0;
   int consumed = 0;
   int buffered = 0;
   int total = 0;
   int idle_due = -1;
   bit busy = 1'b0;
   int hold_fires = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Memory model, input driver and per-cycle comparison against the model.
   initial begin
      bit          prev_req_stall = 1'b0;
      bit          prev_rd_stall = 1'b0;
      logic [31:0] prev_addr = '0;
      logic [31:0] prev_rdata = '0;
      bit          fresh;
      mresp_t      r;
      forever begin
         @(negedge clk);
         cyc++;
         req_ready   = toggle_rdy ? ((cyc % 2) == 0) : 1'b1;
         rdata_ready = (cyc >= hold_until);
         fresh = 1'b0;
         if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            r = mem_q.pop_front();
            resp_valid = 1'b1;
            resp_data  = r.data;
            fresh      = (r.ep == epoch);
         end else begin
            resp_valid = 1'b0;
            resp_data  = $urandom;
         end
         if (rst) begin
            prev_req_stall = 1'b0;
            prev_rd_stall  = 1'b0;
            continue;
         end
         if (prev_req_stall) begin
            chk("req_hold_valid", 64'(req_valid), 64'd1);
            chk("req_hold_addr", 64'(req_addr), 64'(prev_addr));
         end
         if (prev_rd_stall) begin
            chk("rdata_hold_valid", 64'(rdata_valid), 64'd1);
            chk("rdata_hold_data", 64'(rdata), 64'(prev_rdata));
         end
         chk("req_valid", 64'(req_valid), 64'(exp_addr_q.size() != 0 && (fired - consumed) < 8));
         chk("rdata_valid", 64'(rdata_valid), 64'(buffered != 0));
         if (busy) begin
            if (cyc == idle_due) begin
               chk("idle_after_last", 64'(idle), 64'd1);
               busy = 1'b0;
            end else begin
               chk("idle_busy", 64'(idle), 64'd0);
            end
         end
         if (resp_valid && fresh) begin
            chk("resp_into_full_buf", 64'(buffered < 8), 64'd1);
            buffered++;
         end
         if (req_valid && req_ready) begin
            if (exp_addr_q.size() == 0) chk("extra_request", 64'(req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("req_addr", 64'(req_addr), 64'(exp_addr_q.pop_front()));
            log_addr.push_back(req_addr);
            mem_q.push_back('{data: mem_word(req_addr), due: cyc + lat, ep: epoch});
            fired++;
            if (!rdata_ready) hold_fires++;
         end
         if (rdata_valid && rdata_ready) begin
            if (exp_data_q.size() == 0) chk("extra_word", 64'(rdata), 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("rdata", 64'(rdata), 64'(exp_data_q.pop_front()));
            got_data.push_back(rdata);
            buffered--;
            consumed++;
            if (consumed == total) idle_due = cyc + 1;
         end
         prev_req_stall = req_valid && !req_ready;
         prev_rd_stall  = rdata_valid && !rdata_ready;
         prev_addr      = req_addr;
         prev_rdata     = rdata;
      end
   end

   task automatic start_xfer(input int fm, input logic [31:0] wt, input logic [31:0] ifm);
      logic [31:0] a;
      @(negedge clk); #1;
      exp_addr_q.delete();
      exp_data_q.delete();
      log_addr.delete();
      got_data.delete();
      for (int k = 0; k < 9; k++) begin
         a = wt + 32'(4 * k);
         exp_addr_q.push_back(a);
         exp_data_q.push_back(mem_word(a));
      end
      for (int i = 0; i < fm * fm; i++) begin
         a = ifm + 32'(4 * i);
         exp_addr_q.push_back(a);
         exp_data_q.push_back(mem_word(a));
      end
      total      = 9 + fm * fm;
      fired      = 0;
      consumed   = 0;
      idle_due   = -1;
      hold_fires = 0;
      busy       = 1'b1;
      fm_dim        = 32'(fm);
      wt_base_addr  = wt;
      ifm_base_addr = ifm;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      fm_dim        = $urandom_range(1, 9);
      wt_base_addr  = $urandom;
      ifm_base_addr = $urandom;
   endtask

   task automatic wait_done(input string name, input int max_cycles);
      for (int i = 0; i < max_cycles && busy; i++) begin
         @(negedge clk); #1;
      end
      chk({name, "_timeout"}, 64'(busy), 64'd0);
      chk({name, "_words"}, 64'(consumed), 64'(total));
      chk({name, "_requests"}, 64'(fired), 64'(total));
      busy = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_idle"}, 64'(idle), 64'd1);
      chk({name, "_req_valid"}, 64'(req_valid), 64'd0);
      chk({name, "_req_addr"}, 64'(req_addr), 64'd0);
      chk({name, "_rdata_valid"}, 64'(rdata_valid), 64'd0);
      chk({name, "_rdata"}, 64'(rdata), 64'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("por");
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Baseline transfer: literal pins on addresses and data.
      lat = 2;
      start_xfer(4, 32'h100, 32'h200);
      wait_done("basic", 300);
      chk("basic_nreq", 64'(log_addr.size()), 64'd25);
      if (log_addr.size() == 25) begin
         chk("basic_addr0", 64'(log_addr[0]), 64'h100);
         chk("basic_addr8", 64'(log_addr[8]), 64'h120);
         chk("basic_addr9", 64'(log_addr[9]), 64'h200);
         chk("basic_addr24", 64'(log_addr[24]), 64'h23C);
      end
      if (got_data.size() == 25) begin
         chk("basic_word0", 64'(got_data[0]), 64'hDEAD_0100);
         chk("basic_word24", 64'(got_data[24]), 64'hDEAD_023C);
      end
      repeat (3) @(negedge clk);

      // Zero-size feature map: weights only.
      start_xfer(0, 32'h400, 32'h800);
      wait_done("fm0", 200);
      chk("fm0_nreq", 64'(fired), 64'd9);
      chk("fm0_nwords", 64'(consumed), 64'd9);
      repeat (3) @(negedge clk);

      // Consumer stalled for 50 cycles with slow memory: credit must cap requests.
      lat = 4;
      hold_until = cyc + 52;
      start_xfer(4, 32'h100, 32'h200);
      repeat (48) @(negedge clk);
      #1;
      chk("hold_fires", 64'(hold_fires), 64'd8);
      wait_done("hold", 400);
      chk("hold_total_fires", 64'(hold_fires), 64'd8);
      repeat (3) @(negedge clk);

      // Memory accepting every other cycle.
      lat = 2;
      toggle_rdy = 1'b1;
      start_xfer(4, 32'h1000, 32'h2000);
      wait_done("toggle", 400);
      toggle_rdy = 1'b0;
      repeat (3) @(negedge clk);

      // Address wrap at the top of the address space.
      start_xfer(2, 32'hFFFF_FFF0, 32'hFFFF_FFF8);
      wait_done("wrap", 200);
      if (log_addr.size() == 13) begin
         chk("wrap_addr4", 64'(log_addr[4]), 64'h0);
         chk("wrap_addr11", 64'(log_addr[11]), 64'h0);
      end
      repeat (3) @(negedge clk);

      // Reset after 5 requests, stale responses then arrive while idle.
      lat = 4;
      start_xfer(4, 32'h100, 32'h200);
      for (int i = 0; i < 50 && fired < 5; i++) begin
         @(negedge clk); #1;
      end
      chk("rst_reached5", 64'(fired), 64'd5);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      epoch++;
      exp_addr_q.delete();
      exp_data_q.delete();
      buffered = 0;
      fired    = 0;
      consumed = 0;
      total    = 0;
      busy     = 1'b0;
      idle_due = -1;
      @(negedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 50 && mem_q.size() != 0; i++) begin
         @(negedge clk); #1;
      end
      chk("stale_drained", 64'(mem_q.size()), 64'd0);
      repeat (3) @(negedge clk);
      lat = 2;
      start_xfer(4, 32'h100, 32'h200);
      wait_done("after_rst", 300);
      repeat (3) @(negedge clk);

      // start pulsed during the feature-map phase must be ignored.
      start_xfer(4, 32'h300, 32'h600);
      for (int i = 0; i < 50 && fired < 12; i++) begin
         @(negedge clk); #1;
      end
      fm_dim        = 32'd2;
      wt_base_addr  = 32'h900;
      ifm_base_addr = 32'hA00;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      wait_done("ignore_start", 300);
      chk("ignore_start_count", 64'(consumed), 64'd25);
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
